// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: ALU function codes
// for the divide group, FSM state encodings and small decode helpers.
package div_seq_ctrl_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 5;

  // ALU function codes of the divide group (other ALU codes are never divides)
  localparam logic [4:0] ALU_DIV  = 5'h0C;
  localparam logic [4:0] ALU_DIVU = 5'h0D;
  localparam logic [4:0] ALU_REM  = 5'h0E;
  localparam logic [4:0] ALU_REMU = 5'h0F;

  // Sequencer states: waiting for a miss, or iterating one bit per cycle
  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_CALC = 1'b1
  } div_state_e;

  // True for any of the four divide/remainder function codes
  function automatic logic is_div_func(input logic [4:0] func);
    return (func == ALU_DIV) || (func == ALU_DIVU) ||
           (func == ALU_REM) || (func == ALU_REMU);
  endfunction

  // True for the signed flavours; DIV and REM share the same signed run
  function automatic logic is_signed_func(input logic [4:0] func);
    return (func == ALU_DIV) || (func == ALU_REM);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into
// the partial remainder, try subtracting the divisor, keep the difference
// when it does not borrow, otherwise restore the shifted value.
module div_seq_ctrl_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dvd_bit,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;
  logic            unused_trial_msb;

  // The shifted remainder needs XLEN+1 bits; the extra top bit of the trial
  // result is the borrow that selects restore. When no borrow occurs the
  // difference is below the divisor, so its bit XLEN is always zero.
  always_comb begin
    shifted          = {rem_in, dvd_bit};
    trial            = {1'b0, shifted} - {2'b00, divisor};
    q_bit            = ~trial[XLEN+1];
    rem_out          = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    unused_trial_msb = trial[XLEN];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the EX-stage integer divide path. Runs an
// iterative restoring divider one quotient bit per cycle, stalls the
// pipeline through busy, resolves divide-by-zero and signed overflow in a
// single cycle, and keeps a one-entry result cache so a DIV/REM pair on the
// same operands costs one run and a held instruction never restarts.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      alu_func,
  input  logic            vld,
  input  logic            flush,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy,
  output logic            done
);

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;

  // Result cache and its operand tag
  logic             c_vld;
  logic             c_sgn;
  logic [XLEN-1:0]  c_opa;
  logic [XLEN-1:0]  c_opb;
  logic [XLEN-1:0]  c_q;
  logic [XLEN-1:0]  c_r;

  // Operands of the run in progress; these, not the live inputs, get cached
  logic             t_sgn;
  logic [XLEN-1:0]  t_opa;
  logic [XLEN-1:0]  t_opb;

  // Iteration datapath state
  logic [XLEN-1:0]  dvd_mag;
  logic [XLEN-1:0]  dvs_mag;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  prem;
  logic [XLEN-2:0]  q_acc;

  // Combinational decode and step results
  logic             is_div;
  logic             sgn;
  logic             hit;
  logic             req;
  logic             div_zero;
  logic             div_ovf;
  logic             calc_last;
  logic [XLEN-1:0]  opa_mag;
  logic [XLEN-1:0]  opb_mag;
  logic [XLEN-1:0]  rem_next;
  logic             q_bit;
  logic [XLEN-1:0]  q_raw;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;

  div_seq_ctrl_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem_in  (prem),
    .divisor (dvs_mag),
    .dvd_bit (dvd_mag[cnt]),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Decode, cache lookup, special-case detection, sign fixups and the
  // stall/done strobes. busy and done must act in the same cycle as the
  // request and the cache write, so they are combinational, and both are
  // held low while reset is asserted. The magnitude of the most negative
  // value wraps back to itself, which reads correctly as unsigned.
  always_comb begin
    is_div    = vld && is_div_func(alu_func);
    sgn       = is_signed_func(alu_func);
    hit       = c_vld && (opa == c_opa) && (opb == c_opb) && (sgn == c_sgn);
    req       = is_div && !hit && !flush;
    div_zero  = (opb == '0);
    div_ovf   = sgn && (opa == MIN_NEG) && (opb == '1);
    opa_mag   = (sgn && opa[XLEN-1]) ? -opa : opa;
    opb_mag   = (sgn && opb[XLEN-1]) ? -opb : opb;
    q_raw     = {q_acc, q_bit};
    q_fix     = neg_q ? -q_raw : q_raw;
    r_fix     = neg_r ? -rem_next : rem_next;
    calc_last = (state == DIV_CALC) && (cnt == '0) && !flush;
    busy      = rst && req;
    done      = rst && (((state == DIV_IDLE) && req && (div_zero || div_ovf)) ||
                        calc_last);
  end

  // Sequencer FSM with the cache and iteration registers; flush always wins
  // and abandons any run without touching the cache.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      c_vld   <= 1'b0;
      c_sgn   <= 1'b0;
      c_opa   <= '0;
      c_opb   <= '0;
      c_q     <= '0;
      c_r     <= '0;
      t_sgn   <= 1'b0;
      t_opa   <= '0;
      t_opb   <= '0;
      dvd_mag <= '0;
      dvs_mag <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      prem    <= '0;
      q_acc   <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (req) begin
            if (div_zero) begin
              c_q   <= '1;
              c_r   <= opa;
              c_vld <= 1'b1;
              c_opa <= opa;
              c_opb <= opb;
              c_sgn <= sgn;
            end else if (div_ovf) begin
              c_q   <= MIN_NEG;
              c_r   <= '0;
              c_vld <= 1'b1;
              c_opa <= opa;
              c_opb <= opb;
              c_sgn <= sgn;
            end else begin
              dvd_mag <= opa_mag;
              dvs_mag <= opb_mag;
              neg_q   <= sgn & (opa[XLEN-1] ^ opb[XLEN-1]);
              neg_r   <= sgn & opa[XLEN-1];
              t_opa   <= opa;
              t_opb   <= opb;
              t_sgn   <= sgn;
              prem    <= '0;
              q_acc   <= '0;
              cnt     <= CNT_LAST;
              state   <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          prem  <= rem_next;
          q_acc <= {q_acc[XLEN-3:0], q_bit};
          if (cnt == '0) begin
            c_q   <= q_fix;
            c_r   <= r_fix;
            c_vld <= 1'b1;
            c_opa <= t_opa;
            c_opb <= t_opb;
            c_sgn <= t_sgn;
            state <= DIV_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= DIV_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign quotient  = c_q;
  assign remainder = c_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: normal runs, cache reuse, special
// cases, flush, async reset and signed/unsigned cache separation.
module tb_div_seq_ctrl;
  import div_seq_ctrl_pkg::*;

  localparam logic [4:0] ALU_ADD = 5'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [4:0]  alu_func;
  logic        vld;
  logic        flush;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;
  int done_cycles;
  int done_at;

  div_seq_ctrl #(
    .XLEN  (32),
    .CNT_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opa       (opa),
    .opb       (opb),
    .alu_func  (alu_func),
    .vld       (vld),
    .flush     (flush),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Hard stop if the bench ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] func, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    alu_func = func;
    opa      = a;
    opb      = b;
    vld      = 1'b1;
    flush    = 1'b0;
  endtask

  task automatic goIdle();
    @(negedge clk);
    vld      = 1'b0;
    alu_func = ALU_ADD;
  endtask

  // Issue an op and hold it until busy drops, counting busy and done cycles
  task automatic runOp(input logic [4:0] func, input logic [31:0] a,
                       input logic [31:0] b);
    applyStimulus(func, a, b);
    busy_cycles = 0;
    done_cycles = 0;
    done_at     = 0;
    for (int i = 1; i <= 60; i++) begin
      #1;
      if (done) begin
        done_cycles++;
        done_at = i;
      end
      if (!busy) break;
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst      = 1'b0;
    opa      = '0;
    opb      = '0;
    alu_func = ALU_ADD;
    vld      = 1'b0;
    flush    = 1'b0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_q", quotient, 32'd0);
    checkOutput("rst_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] DIVU 100/7");
    runOp(ALU_DIVU, 32'd100, 32'd7);
    checkOutput("divu_busy_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("divu_done_at", 32'(done_at), 32'd33);
    checkOutput("divu_done_count", 32'(done_cycles), 32'd1);
    checkOutput("divu_q", quotient, 32'd14);
    checkOutput("divu_r", remainder, 32'd2);

    $display("[TB] DIV -7/2 then REM reuse");
    runOp(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_neg_busy_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("div_neg_q", quotient, 32'hFFFF_FFFD);
    runOp(ALU_REM, 32'hFFFF_FFF9, 32'd2);
    checkOutput("rem_hit_busy_cycles", 32'(busy_cycles), 32'd0);
    checkOutput("rem_hit_done", 32'(done_cycles), 32'd0);
    checkOutput("rem_hit_r", remainder, 32'hFFFF_FFFF);

    $display("[TB] divide by zero and signed overflow");
    runOp(ALU_DIV, 32'd5, 32'd0);
    checkOutput("dz_busy_cycles", 32'(busy_cycles), 32'd1);
    checkOutput("dz_done_at", 32'(done_at), 32'd1);
    checkOutput("dz_q", quotient, 32'hFFFF_FFFF);
    checkOutput("dz_r", remainder, 32'd5);
    runOp(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("ovf_busy_cycles", 32'(busy_cycles), 32'd1);
    checkOutput("ovf_q", quotient, 32'h8000_0000);
    checkOutput("ovf_r", remainder, 32'd0);

    $display("[TB] unrelated op keeps cache");
    applyStimulus(ALU_ADD, 32'd1, 32'd2);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("nondiv_busy", {31'd0, busy}, 32'd0);
    checkOutput("nondiv_done", {31'd0, done}, 32'd0);
    runOp(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("retain_busy_cycles", 32'(busy_cycles), 32'd0);

    $display("[TB] flush mid-run");
    applyStimulus(ALU_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("calc_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    checkOutput("flush_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    alu_func = ALU_DIV;
    opa      = 32'h8000_0000;
    opb      = 32'hFFFF_FFFF;
    #1;
    checkOutput("flush_cache_hit", {31'd0, busy}, 32'd0);
    checkOutput("flush_cache_q", quotient, 32'h8000_0000);
    runOp(ALU_DIVU, 32'd1000, 32'd3);
    checkOutput("reissue_busy_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("reissue_q", quotient, 32'd333);
    checkOutput("reissue_r", remainder, 32'd1);

    $display("[TB] flush on final step");
    goIdle();
    applyStimulus(ALU_DIVU, 32'd50, 32'd5);
    repeat (32) @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flush_last_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    vld   = 1'b0;
    runOp(ALU_DIVU, 32'd50, 32'd5);
    checkOutput("flush_last_rerun_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("flush_last_q", quotient, 32'd10);

    $display("[TB] async reset mid-run");
    runOp(ALU_DIVU, 32'd9, 32'd3);
    checkOutput("pre_rst_q", quotient, 32'd3);
    applyStimulus(ALU_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_q", quotient, 32'd0);
    checkOutput("arst_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b0;
    runOp(ALU_DIVU, 32'd9, 32'd3);
    checkOutput("post_rst_busy_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("post_rst_q", quotient, 32'd3);
    checkOutput("post_rst_r", remainder, 32'd0);

    $display("[TB] signed/unsigned cache separation");
    runOp(ALU_DIVU, 32'hFFFF_FFFE, 32'd2);
    checkOutput("sep_divu_q", quotient, 32'h7FFF_FFFF);
    checkOutput("sep_divu_r", remainder, 32'd0);
    runOp(ALU_DIV, 32'hFFFF_FFFE, 32'd2);
    checkOutput("sep_div_busy_cycles", 32'(busy_cycles), 32'd33);
    checkOutput("sep_div_q", quotient, 32'hFFFF_FFFF);
    checkOutput("sep_div_r", remainder, 32'd0);

    goIdle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
